// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor. Each stage handles one SEG-bit segment,
// computing it for both carry-ins and selecting with the carry registered by the previous stage.
module pipelined_csel_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The whole pipe shifts only when the result register is empty or being drained,
    // so in_ready depends on out_valid/out_ready alone, never on in_valid.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // op_*[k] are the inputs of stage k; r_*[k] are the registers stage k loads.
    logic [WIDTH-1:0] op_a   [NSEG];
    logic [WIDTH-1:0] op_be  [NSEG];
    logic [WIDTH-1:0] op_res [NSEG];
    logic             op_c   [NSEG];
    logic             op_v   [NSEG];
    logic [WIDTH-1:0] r_a    [NSEG];
    logic [WIDTH-1:0] r_be   [NSEG];
    logic [WIDTH-1:0] r_res  [NSEG];
    logic             r_c    [NSEG];
    logic             r_v    [NSEG];

    // Subtraction is a + ~b + 1, so the borrow-in becomes an inverted carry-in.
    assign op_a[0]   = a;
    assign op_be[0]  = sub ? ~b : b;
    assign op_res[0] = '0;
    assign op_c[0]   = cin ^ sub;
    assign op_v[0]   = in_valid && adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG:0]     s0;
        logic [SEG:0]     s1;
        logic [SEG-1:0]   sel_s;
        logic             sel_c;
        logic [WIDTH-1:0] nxt_res;

        if (k > 0) begin : g_link
            assign op_a[k]   = r_a[k-1];
            assign op_be[k]  = r_be[k-1];
            assign op_res[k] = r_res[k-1];
            assign op_c[k]   = r_c[k-1];
            assign op_v[k]   = r_v[k-1];
        end

        assign s0    = {1'b0, op_a[k][k*SEG +: SEG]} + {1'b0, op_be[k][k*SEG +: SEG]};
        assign s1    = {1'b0, op_a[k][k*SEG +: SEG]} + {1'b0, op_be[k][k*SEG +: SEG]} + (SEG+1)'(1);
        assign sel_s = op_c[k] ? s1[SEG-1:0] : s0[SEG-1:0];
        assign sel_c = op_c[k] ? s1[SEG] : s0[SEG];

        always_comb begin
            nxt_res                = op_res[k];
            nxt_res[k*SEG +: SEG]  = sel_s;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v[k]   <= 1'b0;
                r_c[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_be[k]  <= '0;
                r_res[k] <= '0;
            end else if (adv) begin
                r_v[k]   <= op_v[k];
                r_c[k]   <= sel_c;
                r_a[k]   <= op_a[k];
                r_be[k]  <= op_be[k];
                r_res[k] <= nxt_res;
            end
        end

        if (k == NSEG - 1) begin : g_flags
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf  <= 1'b0;
                    zero <= 1'b0;
                end else if (adv) begin
                    ovf  <= op_a[k][WIDTH-1] ^ op_be[k][WIDTH-1] ^ sel_s[SEG-1] ^ sel_c;
                    zero <= (nxt_res == '0);
                end
            end
        end
    end

    assign out_valid = r_v[NSEG-1];
    assign sum       = r_res[NSEG-1];
    assign cout      = r_c[NSEG-1];

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Bench for pipelined_csel_addsub: table of hand-computed vectors applied to three
// segmentations (NSEG = 2, 4, 1) plus backpressure and asynchronous-reset sequences.
module tb_pipelined_csel_addsub;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_ready_x  [3];
    logic         out_valid_x [3];
    logic         cout_x      [3];
    logic         ovf_x       [3];
    logic         zero_x      [3];
    logic [W-1:0] sum_x       [3];

    pipelined_csel_addsub #(.WIDTH(W), .SEG(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_x[0]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_x[0]), .out_ready(out_ready),
        .sum(sum_x[0]), .cout(cout_x[0]), .ovf(ovf_x[0]), .zero(zero_x[0])
    );
    pipelined_csel_addsub #(.WIDTH(W), .SEG(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_x[1]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_x[1]), .out_ready(out_ready),
        .sum(sum_x[1]), .cout(cout_x[1]), .ovf(ovf_x[1]), .zero(zero_x[1])
    );
    pipelined_csel_addsub #(.WIDTH(W), .SEG(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_x[2]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_x[2]), .out_ready(out_ready),
        .sum(sum_x[2]), .cout(cout_x[2]), .ovf(ovf_x[2]), .zero(zero_x[2])
    );

    int           nseg_x [3] = '{2, 4, 1};
    vec_t         vecs [14];
    logic [W+2:0] exp_q [3][$];
    int           acc_q [3][$];
    logic [W+2:0] cur_exp;
    logic [W+2:0] held_val [3];
    logic         held [3];
    logic [W+2:0] got_v;
    logic [W+2:0] exp_v;
    int           acc_n;
    int           checks = 0;
    int           errors = 0;
    int           negc = 0;
    bit           lat_en = 1'b1;

    task automatic chk(input string nm, input int id, input logic [W+3:0] got, input logic [W+3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, id, got, exp);
        end
    endtask

    // scoreboard: predicted results are queued on accept, popped on each output transfer
    always @(negedge clk) begin
        negc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                held[i] = 1'b0;
            end else begin
                got_v = {cout_x[i], ovf_x[i], zero_x[i], sum_x[i]};
                chk("in_ready", i, {35'd0, in_ready_x[i]}, {35'd0, (!out_valid_x[i] || out_ready)});
                if (held[i])
                    chk("stable", i, {out_valid_x[i], got_v}, {1'b1, held_val[i]});
                held[i]     = out_valid_x[i] && !out_ready;
                held_val[i] = got_v;
                if (out_valid_x[i] && out_ready) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out dut%0d: got %h with nothing expected", i, got_v);
                    end else begin
                        exp_v = exp_q[i].pop_front();
                        acc_n = acc_q[i].pop_front();
                        chk("result", i, {1'b0, got_v}, {1'b0, exp_v});
                        if (lat_en)
                            chk("latency", i, 36'(negc - acc_n), 36'(nseg_x[i]));
                    end
                end
                if (in_valid && in_ready_x[i]) begin
                    exp_q[i].push_back(cur_exp);
                    acc_q[i].push_back(negc);
                end
            end
        end
    end

    // driver tasks
    task automatic drive_op(input int idx);
        bit acc;
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        sub      = vecs[idx].sub;
        cin      = vecs[idx].cin;
        cur_exp  = {vecs[idx].cout, vecs[idx].ovf, vecs[idx].zero, vecs[idx].sum};
        in_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            acc = in_ready_x[0];
            @(posedge clk);
            #1;
            if (acc) return;
        end
        checks++;
        errors++;
        $display("FAIL accept: op %0d not accepted within 30 cycles", idx);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #2;
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL drain: results still pending after 40 cycles");
    endtask

    initial begin
        vecs[0]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h00000009, 32'h00000004, 1'b1, 1'b1, 32'h00000004, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b1, 32'h9999999A, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        cur_exp   = '0;

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk("reset_out", i, {out_valid_x[i], cout_x[i], ovf_x[i], zero_x[i], sum_x[i]}, 36'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            chk("ready_after_reset", i, {35'd0, in_ready_x[i]}, 36'd1);

        // isolated operations
        for (int v = 0; v < 14; v++) begin
            drive_op(v);
            drain();
        end

        // back-to-back stream, one accept per cycle
        for (int v = 0; v < 14; v++)
            drive_op(v);
        drain();

        // backpressure: hold the first result for three cycles
        lat_en = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    drive_op(i + 6);
                in_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 20 && !out_valid_x[0]; n++) begin
                    @(posedge clk);
                    #1;
                end
                if (!out_valid_x[0]) begin
                    checks++;
                    errors++;
                    $display("FAIL bp_wait dut0: out_valid never rose");
                end else begin
                    out_ready = 1'b0;
                    repeat (3) begin
                        @(posedge clk);
                        #1;
                        chk("hold_in_ready", 0, {35'd0, in_ready_x[0]}, 36'd0);
                        chk("hold_out_valid", 0, {35'd0, out_valid_x[0]}, 36'd1);
                    end
                    out_ready = 1'b1;
                end
            end
        join
        drain();
        lat_en = 1'b1;

        // asynchronous reset with two operations in flight
        drive_op(0);
        drive_op(1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_reset", i, {out_valid_x[i], cout_x[i], ovf_x[i], zero_x[i], sum_x[i]}, 36'd0);
            exp_q[i].delete();
            acc_q[i].delete();
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk("reset_held", i, {35'd0, out_valid_x[i]}, 36'd0);
        #2 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            chk("ready_after_async", i, {35'd0, in_ready_x[i]}, 36'd1);
        drive_op(6);
        drain();
        repeat (6) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
